seq_detect_scheduler: RTL
=========================

// Module: seq_detect_scheduler
// PURPOSE
//  Shares one 9-bit Moore sequence detector ("101100100", 7-seg state display) between two requesters.
//  Round-robin grants a WORD_W-bit pattern word and clears the detector with a one-cycle reset pulse.
//  Then streams the word MSB-first, one bit per clock, and counts detector hits from its LED output.
//  Reports per-word hit count and keeps saturating per-requester totals. Sits between host logic and detector.
// PARAMETERS
//  WORD_W      16          bits per pattern word (>=2)
//  HIT_W       8           width of per-word hit count
//  CNT_W       8           width of per-requester saturating totals
//  MATCH_CODE  7'b0000100  det_led value meaning "full sequence detected" (state 9)
// PORTS
//  clock         in   1       single system clock, rising edge
//  reset         in   1       asynchronous, active-high
//  req0_valid    in   1       requester 0 has a word
//  req0_data     in   WORD_W  requester 0 word
//  req0_ready    out  1       requester 0 word accepted this cycle (valid&&ready)
//  req1_valid    in   1       requester 1 has a word
//  req1_data     in   WORD_W  requester 1 word
//  req1_ready    out  1       requester 1 word accepted this cycle
//  det_reset     out  1       drives detector reset
//  det_bit       out  1       drives detector sequence_in
//  det_led       in   7       detector LED_out (state display)
//  done_valid    out  1       one-cycle pulse: word finished
//  done_id       out  1       requester of finished word
//  done_hits     out  HIT_W   detections in finished word
//  match_count0  out  CNT_W   total hits for requester 0, saturating
//  match_count1  out  CNT_W   total hits for requester 1, saturating
// BEHAVIOUR
//  Reset values: state=IDLE, det_reset=1, det_bit=0, readys=0, done_valid=0, done_id=0, done_hits=0,
//   match_count0/1=0, hits=0, rr pointer=requester 0. Reset mid-word abandons word; no done pulse.
//  FSM: IDLE -> CLEAR -> SHIFT (WORD_W cycles) -> DRAIN -> REPORT -> IDLE.
//  IDLE: grant by rr pointer. Only one valid: grant it. Both valid: grant pointer's requester. None: stay.
//   reqX_ready = (state==IDLE) & grantX & !reset, combinational. On accept, latch data into shreg, clear hits.
//  CLEAR (1 cycle): det_reset=1, det_bit=0; bit_cnt=WORD_W-1. det_reset=0 in all states except CLEAR and reset.
//  SHIFT: det_bit = shreg[WORD_W-1]; shreg shifts left each cycle; leave after bit_cnt==0.
//  Hit counting: in every SHIFT and DRAIN cycle, if det_led==MATCH_CODE then hits<=hits+1 (saturate at max).
//   Detector LED lags its input bit by one cycle; DRAIN catches the effect of the last bit.
//  DRAIN (1 cycle): det_bit=0.
//  REPORT (1 cycle): done_valid=1, done_id=granted id, done_hits=hits (held until next REPORT).
//   match_countX += hits, clamped to 2^CNT_W-1. Set rr pointer to the other requester.
//  Latency: accept in cycle 0 -> CLEAR c1, SHIFT c2..c(WORD_W+1), DRAIN c(WORD_W+2), done_valid c(WORD_W+3).
//   Next accept no earlier than c(WORD_W+4), so one word per WORD_W+4 cycles.
//  Requesters must hold valid/data until ready. A valid deasserted before grant is not latched.
//  Requester inputs are ignored outside IDLE.
// TESTING
//  1. req0 word 16'hB200 (101100100 then zeros) -> done at c19, done_id=0, done_hits=1, match_count0=1.
//  2. req1 word 16'h0000 -> det_bit all 0, done_hits=0, match_count1 unchanged; det_reset high only in c1.
//  3. Both valid after reset, words 16'hB200/16'hFFFF -> req0 served first, then req1.
//     Then both again -> req0 next (alternating); ready never high for both in the same cycle.
//  4. CNT_W=2, four req0 words of 16'hB200 -> match_count0 reads 1,2,3,3 (saturates).
//  5. Assert reset during SHIFT of req0 word -> all outputs at reset values immediately, det_reset=1.
//     No done_valid; after release, a fresh word completes normally.
//  6. Check det_bit on 16'hB200 -> bits 1,0,1,1,0,0,1,0,0,0,... in c2..c17.
//     Hit counted from det_led==MATCH_CODE in c11.

Source files
------------

// File: rtl/seq_detect_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_scheduler
// Purpose  : Round-robin sharing of one "101100100" Moore detector between two
//            requesters; streams each word MSB-first and reports hit counts.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_scheduler #(
  parameter int         WORD_W     = 16,
  parameter int         HIT_W      = 8,
  parameter int         CNT_W      = 8,
  parameter logic [6:0] MATCH_CODE = 7'b0000100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              det_reset,
  output logic              det_bit,
  input  logic [6:0]        det_led,
  output logic              done_valid,
  output logic              done_id,
  output logic [HIT_W-1:0]  done_hits,
  output logic [CNT_W-1:0]  match_count0,
  output logic [CNT_W-1:0]  match_count1
);

  localparam int                 c_BIT_W    = $clog2(WORD_W);
  localparam int                 c_SUM_W    = ((CNT_W > HIT_W) ? CNT_W : HIT_W) + 1;
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WORD_W - 1);
  localparam logic [HIT_W-1:0]   c_HIT_MAX  = {HIT_W{1'b1}};
  localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_CLEAR  = 3'd1;
  localparam logic [2:0] c_ST_SHIFT  = 3'd2;
  localparam logic [2:0] c_ST_DRAIN  = 3'd3;
  localparam logic [2:0] c_ST_REPORT = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [WORD_W-1:0]  r_shreg;
  logic [c_BIT_W-1:0] r_bit_cnt;
  logic [HIT_W-1:0]   r_hits;
  logic [HIT_W-1:0]   w_hits_next;
  logic               r_gnt_id;
  logic               r_rr;
  logic               r_done_id;
  logic [HIT_W-1:0]   r_done_hits;
  logic [CNT_W-1:0]   r_match_count0;
  logic [CNT_W-1:0]   r_match_count1;
  logic [CNT_W-1:0]   w_match_next0;
  logic [CNT_W-1:0]   w_match_next1;
  logic [c_SUM_W-1:0] w_sum0;
  logic [c_SUM_W-1:0] w_sum1;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_hit;

  // Contention goes to the requester named by the round-robin pointer.
  assign w_gnt0 = req0_valid & (~req1_valid | ~r_rr);
  assign w_gnt1 = req1_valid & (~req0_valid | r_rr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE:   if (w_gnt0 | w_gnt1) w_state_next = c_ST_CLEAR;
      c_ST_CLEAR:  w_state_next = c_ST_SHIFT;
      c_ST_SHIFT:  if (r_bit_cnt == '0) w_state_next = c_ST_DRAIN;
      c_ST_DRAIN:  w_state_next = c_ST_REPORT;
      c_ST_REPORT: w_state_next = c_ST_IDLE;
      default:     w_state_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (r_state == c_ST_IDLE) & w_gnt0 & ~reset;
    req1_ready = (r_state == c_ST_IDLE) & w_gnt1 & ~reset;
    det_reset  = reset | (r_state == c_ST_CLEAR);
    det_bit    = (r_state == c_ST_SHIFT) & r_shreg[WORD_W-1];
    done_valid = (r_state == c_ST_REPORT);
  end

  // The LED trails the streamed bit by one clock, so DRAIN still samples it.
  assign w_hit       = ((r_state == c_ST_SHIFT) || (r_state == c_ST_DRAIN)) &&
                       (det_led == MATCH_CODE);
  assign w_hits_next = (w_hit && (r_hits != c_HIT_MAX)) ? r_hits + HIT_W'(1) : r_hits;

  assign w_sum0        = c_SUM_W'(r_match_count0) + c_SUM_W'(w_hits_next);
  assign w_sum1        = c_SUM_W'(r_match_count1) + c_SUM_W'(w_hits_next);
  assign w_match_next0 = (w_sum0 > c_SUM_W'(c_CNT_MAX)) ? c_CNT_MAX : w_sum0[CNT_W-1:0];
  assign w_match_next1 = (w_sum1 > c_SUM_W'(c_CNT_MAX)) ? c_CNT_MAX : w_sum1[CNT_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shreg        <= '0;
      r_bit_cnt      <= '0;
      r_hits         <= '0;
      r_gnt_id       <= 1'b0;
      r_rr           <= 1'b0;
      r_done_id      <= 1'b0;
      r_done_hits    <= '0;
      r_match_count0 <= '0;
      r_match_count1 <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_shreg  <= w_gnt0 ? req0_data : req1_data;
            r_gnt_id <= w_gnt1;
            r_hits   <= '0;
          end
        end
        c_ST_CLEAR: begin
          r_bit_cnt <= c_BIT_LAST;
        end
        c_ST_SHIFT: begin
          r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt - c_BIT_W'(1);
          r_hits    <= w_hits_next;
        end
        c_ST_DRAIN: begin
          // Results land here so they are visible alongside the done pulse.
          r_hits      <= w_hits_next;
          r_done_hits <= w_hits_next;
          r_done_id   <= r_gnt_id;
          if (r_gnt_id) begin
            r_match_count1 <= w_match_next1;
          end else begin
            r_match_count0 <= w_match_next0;
          end
        end
        c_ST_REPORT: begin
          r_rr <= ~r_gnt_id;
        end
        default: begin
          r_hits <= r_hits;
        end
      endcase
    end
  end

  assign done_id      = r_done_id;
  assign done_hits    = r_done_hits;
  assign match_count0 = r_match_count0;
  assign match_count1 = r_match_count1;

endmodule
`default_nettype wire
